// File: rtl/s_array_init_gen.sv
// RC5/RC6 S-table initialiser: streams S[i] = PW + i*QW (mod 2^W) into the S-array RAM
// over a ready/valid write port, then pulses done for the key-mixing stage.
module s_array_init_gen #(
  parameter int W     = 32,
  parameter int R_MAX = 20,
  parameter int T_MAX = 2*R_MAX+4,
  parameter int A_W   = $clog2(T_MAX),
  parameter logic [W-1:0] PW = (W == 16) ? W'(16'hB7E1) :
                               (W == 64) ? W'(64'hB7E151628AED2A6B) : W'(32'hB7E15163),
  parameter logic [W-1:0] QW = (W == 16) ? W'(16'h9E37) :
                               (W == 64) ? W'(64'h9E3779B97F4A7C15) : W'(32'h9E3779B9)
) (
  input  logic           clk2,
  input  logic           rst,
  input  logic           start,
  input  logic           mode,
  input  logic [7:0]     rounds,
  input  logic           wr_ready,
  output logic           wr_en,
  output logic [A_W-1:0] wr_addr,
  output logic [W-1:0]   wr_data,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [A_W:0]   t_len
);

  localparam int TLW = A_W + 1;
  localparam logic [7:0] RMAX8 = 8'(R_MAX);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t         state_q, state_d;
  logic           wr_en_q, wr_en_d;
  logic [A_W-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]   wr_data_q, wr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [A_W:0]   t_len_q, t_len_d;

  logic           cfg_ok;
  logic [A_W:0]   cfg_len;
  logic           last_word;

  // Legal rounds keep 2r+4 within T_MAX, so the truncating cast never loses bits.
  assign cfg_ok    = (rounds != 8'd0) && (rounds <= RMAX8);
  assign cfg_len   = TLW'({rounds, 1'b0}) + (mode ? TLW'(4) : TLW'(2));
  assign last_word = ({1'b0, wr_addr_q} == (t_len_q - TLW'(1)));

  always_ff @(posedge clk2 or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      t_len_q   <= '0;
    end else begin
      state_q   <= state_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      t_len_q   <= t_len_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    t_len_d   = t_len_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            t_len_d   = cfg_len;
            wr_addr_d = '0;
            wr_data_d = PW;
            wr_en_d   = 1'b1;
            busy_d    = 1'b1;
            state_d   = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WRITE: begin
        // wr_en is always high here; a stalled RAM simply freezes addr/data.
        if (wr_ready) begin
          if (last_word) begin
            wr_en_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            wr_addr_d = wr_addr_q + A_W'(1);
            wr_data_d = wr_data_q + QW;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign t_len   = t_len_q;

endmodule

// File: tb/tb_s_array_init_gen.sv
// Bench for s_array_init_gen: W=32 and W=16 instances checked against S[i] = P + i*Q mod 2^W.
module tb_s_array_init_gen;

  logic        clk2 = 1'b0;
  logic        rst;
  logic        start, mode, wr_ready;
  logic [7:0]  rounds;
  logic        wr_en, busy, done, err;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [6:0]  t_len;

  logic        start16, mode16, wr_ready16;
  logic [7:0]  rounds16;
  logic        wr_en16, busy16, done16, err16;
  logic [5:0]  wr_addr16;
  logic [15:0] wr_data16;
  logic [6:0]  t_len16;

  always #5 clk2 = ~clk2;

  s_array_init_gen #(.W(32)) u32 (
    .clk2(clk2), .rst(rst), .start(start), .mode(mode), .rounds(rounds),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err), .t_len(t_len));

  s_array_init_gen #(.W(16)) u16 (
    .clk2(clk2), .rst(rst), .start(start16), .mode(mode16), .rounds(rounds16),
    .wr_ready(wr_ready16), .wr_en(wr_en16), .wr_addr(wr_addr16), .wr_data(wr_data16),
    .busy(busy16), .done(done16), .err(err16), .t_len(t_len16));

  int n_chk = 0;
  int n_pass = 0;

  // Accepted-transfer log, captured on the edge where the RAM takes the word.
  int          aq[$];
  logic [31:0] dq[$];
  int          aq16[$];
  logic [15:0] dq16[$];
  logic        x_edge = 1'b0;

  always @(posedge clk2) begin
    if (!rst && wr_en && wr_ready) begin
      aq.push_back(int'(wr_addr));
      dq.push_back(wr_data);
      x_edge = 1'b1;
    end else begin
      x_edge = 1'b0;
    end
    if (!rst && wr_en16 && wr_ready16) begin
      aq16.push_back(int'(wr_addr16));
      dq16.push_back(wr_data16);
    end
  end

  function automatic logic [31:0] s32(input int i);
    return 32'hB7E15163 + 32'(i) * 32'h9E3779B9;
  endfunction

  function automatic logic [15:0] s16(input int i);
    return 16'hB7E1 + 16'(i) * 16'h9E37;
  endfunction

  function automatic int tlen_ref(input logic m, input int r);
    return m ? 2*r + 4 : 2*r + 2;
  endfunction

  // Results of the most recent drive_run
  int          busy_cyc, hold_cyc, hold_bad, hold_addr, tlen_done;
  logic [31:0] hold_data;
  bit          to, done_seen, done_after, done_on_xfer;

  task automatic drive_run(input logic m, input int r, input int stall_addr,
                           input int stall_len, input bit rnd);
    int cyc, left;
    bit stalled;
    logic [5:0]  pa;
    logic [31:0] pd;
    logic        pr;
    aq.delete(); dq.delete();
    busy_cyc = 0; hold_cyc = 0; hold_bad = 0; hold_addr = -1; hold_data = '0;
    to = 0; done_seen = 0; done_after = 0; done_on_xfer = 0; tlen_done = -1;
    @(negedge clk2); mode = m; rounds = 8'(r); start = 1'b1;
    @(negedge clk2); start = 1'b0;
    cyc = 0; left = 0; stalled = 0; pr = 1'b1; pa = '0; pd = '0;
    while (!done_seen) begin
      if (cyc >= 600) begin to = 1; break; end
      if (!pr) begin
        hold_cyc++;
        if (wr_en !== 1'b1 || wr_addr !== pa || wr_data !== pd) hold_bad++;
        hold_addr = int'(wr_addr); hold_data = wr_data;
      end
      if (busy) busy_cyc++;
      if (done) begin done_seen = 1; tlen_done = int'(t_len); done_on_xfer = x_edge; end
      if (!stalled && stall_len > 0 && wr_en && int'(wr_addr) == stall_addr) begin
        stalled = 1; left = stall_len;
      end
      if (left > 0) begin wr_ready = 1'b0; left--; end
      else wr_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pr = wr_ready || !wr_en; pa = wr_addr; pd = wr_data;
      @(negedge clk2); cyc++;
    end
    wr_ready = 1'b1;
    done_after = done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk2);
    n_chk++; if ({wr_en, busy, done, err} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {wr_en, busy, done, err}); else n_pass++;
    n_chk++; if (wr_addr !== 6'd0) $display("FAIL reset_addr got %0d want 0", wr_addr); else n_pass++;
    n_chk++; if (wr_data !== 32'd0) $display("FAIL reset_data got %h want 0", wr_data); else n_pass++;
    n_chk++; if (t_len !== 7'd0) $display("FAIL reset_tlen got %0d want 0", t_len); else n_pass++;
    rst = 1'b0;
    @(negedge clk2);
  endtask

  task automatic test_rc5;
    int bad;
    drive_run(1'b0, 12, -1, 0, 1'b0);
    n_chk++; if (to) $display("FAIL rc5_timeout got timeout want done"); else n_pass++;
    n_chk++; if (aq.size() != 26) $display("FAIL rc5_count got %0d want 26", aq.size()); else n_pass++;
    n_chk++; if (aq.size() < 2 || dq[0] !== 32'hB7E15163 || dq[1] !== 32'h5618CB1C)
      $display("FAIL rc5_s01 got %h %h want B7E15163 5618CB1C", dq[0], dq[1]); else n_pass++;
    bad = 0;
    foreach (aq[i]) if (aq[i] != i || dq[i] !== s32(i)) bad++;
    n_chk++; if (bad != 0) $display("FAIL rc5_seq got %0d bad words want 0", bad); else n_pass++;
    n_chk++; if (tlen_done != 26) $display("FAIL rc5_tlen got %0d want 26", tlen_done); else n_pass++;
    n_chk++; if (!done_on_xfer || done_after) $display("FAIL rc5_done_pulse got on_xfer=%0b after=%0b want 1 0", done_on_xfer, done_after); else n_pass++;
    n_chk++; if (busy_cyc != 26) $display("FAIL rc5_busy got %0d want 26", busy_cyc); else n_pass++;
  endtask

  task automatic test_rc6;
    int bad;
    drive_run(1'b1, 20, -1, 0, 1'b0);
    n_chk++; if (to || aq.size() != 44) $display("FAIL rc6_count got %0d (to=%0b) want 44", aq.size(), to); else n_pass++;
    n_chk++; if (aq.size() == 0 || aq[aq.size()-1] != 43) $display("FAIL rc6_last_addr got %0d want 43", aq.size() ? aq[aq.size()-1] : -1); else n_pass++;
    bad = 0;
    foreach (aq[i]) if (aq[i] != i || dq[i] !== s32(i)) bad++;
    n_chk++; if (bad != 0) $display("FAIL rc6_seq got %0d bad words want 0", bad); else n_pass++;
    n_chk++; if (tlen_done != 44) $display("FAIL rc6_tlen got %0d want 44", tlen_done); else n_pass++;
    n_chk++; if (busy_cyc != 44) $display("FAIL rc6_busy got %0d want 44", busy_cyc); else n_pass++;
  endtask

  task automatic test_backpressure;
    int bad;
    drive_run(1'b0, 12, 5, 3, 1'b0);
    n_chk++; if (hold_cyc != 3 || hold_bad != 0) $display("FAIL bp_hold got cyc=%0d bad=%0d want 3 0", hold_cyc, hold_bad); else n_pass++;
    n_chk++; if (hold_addr != 5 || hold_data !== s32(5)) $display("FAIL bp_value got %0d/%h want 5/%h", hold_addr, hold_data, s32(5)); else n_pass++;
    bad = 0;
    foreach (aq[i]) if (aq[i] != i || dq[i] !== s32(i)) bad++;
    n_chk++; if (to || aq.size() != 26 || bad != 0) $display("FAIL bp_seq got %0d words %0d bad want 26 0", aq.size(), bad); else n_pass++;
    n_chk++; if (!done_on_xfer || done_after) $display("FAIL bp_done_pulse got on_xfer=%0b after=%0b want 1 0", done_on_xfer, done_after); else n_pass++;
  endtask

  task automatic test_illegal;
    int bad_r[2] = '{0, 21};
    int ec, we, bz;
    foreach (bad_r[k]) begin
      @(negedge clk2); mode = k[0]; rounds = 8'(bad_r[k]); start = 1'b1;
      @(negedge clk2); start = 1'b0;
      ec = 0; we = 0; bz = 0;
      repeat (5) begin
        if (err) ec++;
        if (wr_en) we++;
        if (busy) bz++;
        @(negedge clk2);
      end
      n_chk++; if (ec != 1) $display("FAIL illegal_err r=%0d got %0d pulses want 1", bad_r[k], ec); else n_pass++;
      n_chk++; if (we != 0 || bz != 0) $display("FAIL illegal_idle r=%0d got wr_en=%0d busy=%0d want 0 0", bad_r[k], we, bz); else n_pass++;
    end
  endtask

  task automatic test_reset_mid;
    int cyc, dn;
    wr_ready = 1'b1;
    @(negedge clk2); mode = 1'b0; rounds = 8'd12; start = 1'b1;
    @(negedge clk2); start = 1'b0;
    cyc = 0;
    while (wr_addr != 6'd10 && cyc < 100) begin @(negedge clk2); cyc++; end
    n_chk++; if (cyc >= 100) $display("FAIL rmid_reach got timeout want wr_addr=10"); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({wr_en, busy, done, err} !== 4'b0 || wr_addr !== 6'd0 || wr_data !== 32'd0 || t_len !== 7'd0)
      $display("FAIL rmid_zero got en=%0b busy=%0b addr=%0d data=%h tlen=%0d want all 0", wr_en, busy, wr_addr, wr_data, t_len);
    else n_pass++;
    dn = 0;
    repeat (2) begin @(negedge clk2); if (done) dn++; end
    rst = 1'b0;
    repeat (4) begin @(negedge clk2); if (done || wr_en) dn++; end
    n_chk++; if (dn != 0) $display("FAIL rmid_no_done got %0d activity cycles want 0", dn); else n_pass++;
    drive_run(1'b0, 12, -1, 0, 1'b0);
    n_chk++; if (aq.size() == 0 || aq[0] != 0 || dq[0] !== 32'hB7E15163)
      $display("FAIL rmid_restart got %0d/%h want 0/B7E15163", aq.size() ? aq[0] : -1, aq.size() ? dq[0] : 32'h0); else n_pass++;
    n_chk++; if (to || aq.size() != 26) $display("FAIL rmid_count got %0d want 26", aq.size()); else n_pass++;
  endtask

  task automatic test_w16;
    int cyc, dn, tl, bad;
    aq16.delete(); dq16.delete();
    @(negedge clk2); mode16 = 1'b0; rounds16 = 8'd12; start16 = 1'b1;
    @(negedge clk2); start16 = 1'b0;
    repeat (3) @(negedge clk2);
    mode16 = 1'b1; rounds16 = 8'd5; start16 = 1'b1;
    @(negedge clk2); start16 = 1'b0;
    dn = 0; tl = -1;
    for (cyc = 0; cyc < 100; cyc++) begin
      if (done16) begin dn++; tl = int'(t_len16); end
      @(negedge clk2);
    end
    n_chk++; if (aq16.size() != 26) $display("FAIL w16_count got %0d want 26", aq16.size()); else n_pass++;
    n_chk++; if (aq16.size() < 2 || dq16[0] !== 16'hB7E1 || dq16[1] !== 16'h5618)
      $display("FAIL w16_s01 got %h %h want B7E1 5618", dq16[0], dq16[1]); else n_pass++;
    bad = 0;
    foreach (aq16[i]) if (aq16[i] != i || dq16[i] !== s16(i)) bad++;
    n_chk++; if (bad != 0) $display("FAIL w16_seq got %0d bad words want 0", bad); else n_pass++;
    n_chk++; if (dn != 1 || tl != 26) $display("FAIL w16_done got %0d pulses tlen=%0d want 1 26", dn, tl); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int bad, r;
    logic m;
    for (int k = 0; k < 5; k++) begin
      m = 1'($urandom_range(0, 1));
      r = int'($urandom_range(1, 20));
      drive_run(m, r, -1, 0, 1'b1);
      bad = 0;
      foreach (aq[i]) if (aq[i] != i || dq[i] !== s32(i)) bad++;
      n_chk++; if (to || aq.size() != tlen_ref(m, r) || bad != 0)
        $display("FAIL b2b_seq m=%0b r=%0d got %0d words %0d bad want %0d 0", m, r, aq.size(), bad, tlen_ref(m, r)); else n_pass++;
      n_chk++; if (tlen_done != tlen_ref(m, r) || !done_on_xfer || done_after)
        $display("FAIL b2b_done m=%0b r=%0d got tlen=%0d on_xfer=%0b after=%0b want %0d 1 0", m, r, tlen_done, done_on_xfer, done_after, tlen_ref(m, r)); else n_pass++;
      n_chk++; if (hold_bad != 0) $display("FAIL b2b_hold got %0d unstable stall cycles want 0", hold_bad); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; rounds = 8'd0; wr_ready = 1'b1;
    start16 = 1'b0; mode16 = 1'b0; rounds16 = 8'd0; wr_ready16 = 1'b1;
    test_reset();
    test_rc5();
    test_rc6();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_w16();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
